// File: rtl/uds_multiread.sv
// Read port for the unique-device secret ROM: per-word read budget, fixed-latency
// ROM fetch, registered one-cycle ready pulse and an all-words-spent flag.
module uds_multiread #(
    parameter int WORDS      = 8,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32,
    parameter int READ_LIMIT = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              en,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] read_data,
    output logic              ready,
    output logic              busy,
    output logic              all_read,
    output logic              rom_re,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int               CNT_W   = $clog2(READ_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(READ_LIMIT);
    localparam int               SLOTS   = 2 ** ADDR_W;
    localparam logic [3:0]       LAT_LD  = 4'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, FETCH, DENY} state_t;

    state_t            state, state_nxt;
    logic [3:0]        lat, lat_nxt;
    logic [CNT_W-1:0]  cnt     [SLOTS];
    logic [CNT_W-1:0]  cnt_nxt [SLOTS];
    logic              ready_q, ready_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              all_q, all_nxt;
    logic              in_range, allowed, grant;

    assign in_range = {1'b0, address} < (ADDR_W + 1)'(WORDS);
    assign allowed  = cnt[address] < LIMIT;
    assign grant    = cs && en && in_range && allowed;

    // FETCH keeps the FSM out of IDLE through the ready cycle (lat==0), so a
    // request arriving alongside ready is dropped.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        ready_nxt = 1'b0;
        data_nxt  = '0;
        rom_re    = 1'b0;
        rom_addr  = '0;
        busy      = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    rom_re           = 1'b1;
                    rom_addr         = address;
                    cnt_nxt[address] = cnt[address] + 1'b1;
                    lat_nxt          = LAT_LD;
                    state_nxt        = FETCH;
                end else if (cs) begin
                    ready_nxt = 1'b1;
                    state_nxt = DENY;
                end
            end
            FETCH: begin
                if (lat != 4'd0) begin
                    busy    = 1'b1;
                    lat_nxt = lat - 4'd1;
                    if (lat == 4'd1) begin
                        ready_nxt = 1'b1;
                        data_nxt  = rom_data;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            DENY:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        all_nxt = 1'b1;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (cnt_nxt[i] != LIMIT) all_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat     <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            all_q   <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) cnt[i] <= '0;
        end else begin
            state   <= state_nxt;
            lat     <= lat_nxt;
            ready_q <= ready_nxt;
            data_q  <= data_nxt;
            all_q   <= all_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign ready     = ready_q;
    assign read_data = data_q;
    assign all_read  = all_q;

endmodule

// File: doc/uds_multiread.md
Name: uds_multiread

Overview:
- Parametrised successor of the unique-device-secret read port.
- Fronts an external secret ROM that has a fixed multi-cycle latency.
- Enforces a per-word read budget: read-once by default, or up to READ_LIMIT reads per word.
- Returns data through a registered one-cycle ready pulse and reports when every word's budget is spent.
- Sits between the bus decoder and the secret ROM primitive.

Parameters:
- WORDS, 8: number of secret words. Legal range 1..2**ADDR_W.
- ADDR_W, 3: word address width.
- DATA_W, 32: word width.
- READ_LIMIT, 1: reads permitted per word between resets. Must be >= 1.
- RD_LATENCY, 1: cycles from rom_re to valid rom_data. Legal range 1..8.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous active-high reset.
- cs, input, 1: request strobe, one cycle per request.
- en, input, 1: access permitted (firmware mode); sampled with cs.
- address, input, ADDR_W: word index; sampled with cs.
- read_data, output, DATA_W: returned word; valid only while ready=1.
- ready, output, 1: one-cycle response pulse.
- busy, output, 1: ROM fetch in flight.
- all_read, output, 1: every word has reached READ_LIMIT.
- rom_re, output, 1: ROM read enable.
- rom_addr, output, ADDR_W: ROM word address.
- rom_data, input, DATA_W: ROM output data.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on port reset.
- Reset value of every output is 0: ready, read_data, busy, all_read, rom_re, rom_addr. On reset, all per-word counters are cleared to 0 and the FSM returns to IDLE.
- Each word has a saturating counter of width clog2(READ_LIMIT+1). A word is "allowed" when its counter < READ_LIMIT.
- FSM has three states: IDLE, FETCH, DENY.
- IDLE, grant (cs=1, en=1, address < WORDS, word allowed), request in cycle T:
  - rom_re=1 combinationally in cycle T; rom_addr=address.
  - At the end of T: latch address, increment that word's counter (the read is committed at issue), load latency counter with RD_LATENCY, go to FETCH.
- IDLE, deny (cs=1 with en=0, address >= WORDS, or word exhausted): go to DENY. ROM is not accessed and no counter changes.
- IDLE with cs=0: remain in IDLE, no action.
- FETCH:
  - busy=1.
  - Latency counter decrements each cycle.
  - In cycle T+RD_LATENCY, rom_data is valid and is registered.
  - Cycle T+RD_LATENCY+1: ready=1, read_data=captured word, state returns to IDLE.
  - Grant latency is therefore RD_LATENCY+1 cycles after cs.
- DENY: cycle T+1 has ready=1, read_data=0; then return to IDLE.
- read_data is forced to 0 in every cycle where ready=0. The secret is never held on the bus outside the ready pulse.
- cs asserted while in FETCH or DENY is ignored: no ready, no counter change. The requester must wait for ready and then re-issue.
- A new cs in the same cycle that ready is high is ignored (the FSM is not yet in IDLE). Earliest accepted new request is the cycle after ready.
- rom_re is high for exactly one cycle per grant and never in DENY or FETCH.
- all_read is registered. It rises the cycle after the last allowed counter increment and stays high until reset.
- Reset during FETCH aborts the fetch with no ready pulse and clears all counters. The budget is re-armed only by system reset.
- Counters saturate at READ_LIMIT and never wrap.

Test Plan:
- Reset, then WORDS=8, READ_LIMIT=1, RD_LATENCY=1. cs=1, en=1, address=3 in cycle T, ROM word 3 = 0xDEADBEEF -> rom_re=1 and rom_addr=3 in T; ready=1 and read_data=0xDEADBEEF in T+2; busy=1 in T+1.
- Repeat the read of address 3 -> ready=1 in T+1 with read_data=0, rom_re stays 0. Reading address 4 still returns its ROM word.
- en=0 with address=5 -> ready=1 and read_data=0 in T+1. A subsequent en=1 read of address 5 returns the ROM data, confirming no budget was consumed by the denied request.
- READ_LIMIT=2, RD_LATENCY=3: two reads of address 0 -> data at T+4 each; third read -> zero after 1 cycle. Read all 8 words twice -> all_read rises one cycle after the final grant.
- cs pulsed during FETCH at address 6 -> ignored, no extra rom_re. Assert reset mid-FETCH -> no ready; after release, address 3 is readable again. Address 7 with WORDS=6 -> denied with zero data.
